icache_controller: RTL and testbench

ICACHE_CONTROLLER -- requirements
Module: icache_controller

---
 rtl/icache_controller.sv | 127 ++++++++++++
 tb/tb_icache_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache with a zero-cycle hit path and a
// single-outstanding line refill FSM (IDLE -> MISS_REQ -> MISS_WAIT -> FILL).
module icache_controller #(
    parameter int unsigned LINES      = 4,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned INST_LEN   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fet_req_valid,
    input  logic [31:0]               fet_addr,
    output logic [INST_LEN-1:0]       fet_inst,
    output logic                      fet_rdy,
    output logic                      stall_fet_out,
    input  logic                      flush,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0]   mem_resp_data,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORDS  = (LINE_BYTES * 8) / INST_LEN;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned WSEL_W = $clog2(WORDS);
    localparam int unsigned BSEL_W = OFF_W - WSEL_W;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned LADR_W = ADDR_W - OFF_W;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t                              state;
    logic [LINES-1:0]                    valid_q;
    logic [TAG_W-1:0]                    tag_q  [LINES];
    logic [WORDS-1:0][INST_LEN-1:0]      data_q [LINES];
    logic [LADR_W-1:0]                   miss_line;
    logic                                discard;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              idle;
    logic              hit;
    logic              miss;
    logic              fill_write;
    logic              unused_addr;

    assign req_idx     = fet_addr[OFF_W +: IDX_W];
    assign req_tag     = fet_addr[ADDR_W-1 -: TAG_W];
    assign req_word    = fet_addr[BSEL_W +: WSEL_W];
    assign miss_idx    = miss_line[IDX_W-1:0];
    assign miss_tag    = miss_line[LADR_W-1 -: TAG_W];
    assign unused_addr = ^fet_addr[BSEL_W-1:0];

    // Lookup is gated by rst so that no hit or stall escapes while reset is held.
    assign idle       = (state == IDLE) && !rst;
    assign hit        = fet_req_valid && idle && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign miss       = fet_req_valid && idle && !hit;
    assign fill_write = !rst && (state == MISS_WAIT) && mem_resp_valid;

    assign fet_rdy       = hit;
    assign fet_inst      = hit ? data_q[req_idx][req_word] : '0;
    assign stall_fet_out = miss || (!rst && (state != IDLE));
    assign mem_req_valid = !rst && (state == MISS_REQ);
    assign mem_req_addr  = {miss_line, OFF_W'(0)};

    // Control state: FSM, valid bits, discard flag and event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            discard    <= 1'b0;
            miss_line  <= '0;
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit) hit_count <= hit_count + 16'd1;
            if (flush) valid_q <= '0;
            case (state)
                IDLE: begin
                    if (miss) begin
                        state      <= MISS_REQ;
                        miss_line  <= fet_addr[ADDR_W-1:OFF_W];
                        miss_count <= miss_count + 16'd1;
                    end
                end
                MISS_REQ: begin
                    if (flush) discard <= 1'b1;
                    if (mem_req_ready) state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (flush) discard <= 1'b1;
                    if (mem_resp_valid) begin
                        // A flush seen at any point of the refill leaves the line invalid.
                        if (!(discard || flush)) valid_q[miss_idx] <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL: begin
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Directed self-checking bench for icache_controller: hits, misses, refill
// timing, back-pressure, flush and reset interactions.
module tb_icache_controller;

    logic         clk;
    logic         rst;
    logic         fet_req_valid;
    logic [31:0]  fet_addr;
    logic [31:0]  fet_inst;
    logic         fet_rdy;
    logic         stall_fet_out;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int checks = 0;
    int errors = 0;

    icache_controller #(.LINES(4), .LINE_BYTES(16), .INST_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .fet_req_valid(fet_req_valid), .fet_addr(fet_addr),
        .fet_inst(fet_inst), .fet_rdy(fet_rdy), .stall_fet_out(stall_fet_out),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 0 and word 1 both carry 0xDEADBEEF so the cold-miss word matches either reading.
    logic [127:0] line_a = {32'hCAFE_0003, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [127:0] line_b = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
    logic [127:0] line_c = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

    int          hc, sc, ac, rc, m0;
    logic [31:0] ra, ins;
    logic        mv;

    // Memory responder: caller has already driven the miss cycle's fetch inputs.
    task automatic serve_miss(input logic [127:0] line, input int hold, input int resp_n,
                              input int flush_cyc, output int hit_cyc, output int stall_cnt,
                              output int accepts, output int req_cycles,
                              output logic [31:0] req_addr, output logic addr_moved,
                              output logic [31:0] inst);
        int acc_cyc;
        acc_cyc = -100; hit_cyc = -1; stall_cnt = 0; accepts = 0; req_cycles = 0;
        req_addr = '0; addr_moved = 1'b0; inst = '0;
        mem_resp_data = line;
        mem_req_ready = 1'b0;
        flush = (flush_cyc == 0);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (fet_rdy) begin
                hit_cyc = cyc;
                inst = fet_inst;
                break;
            end
            if (stall_fet_out) stall_cnt++;
            if (mem_req_valid) begin
                if (req_cycles > 0 && mem_req_addr !== req_addr) addr_moved = 1'b1;
                req_addr = mem_req_addr;
                req_cycles++;
                if (mem_req_ready) begin
                    accepts++;
                    acc_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            mem_req_ready  = (cyc + 1 >= 1 + hold);
            mem_resp_valid = (cyc + 1 == acc_cyc + resp_n);
            flush          = (cyc + 1 == flush_cyc);
        end
        mem_resp_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fet_req_valid = 1'b1; fet_addr = 32'h10; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (fet_rdy !== 1'b0) begin errors++; $display("FAIL reset_fet_rdy: got %b want 0", fet_rdy); end
        checks++; if (fet_inst !== 32'h0) begin errors++; $display("FAIL reset_fet_inst: got %h want 0", fet_inst); end
        checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_fet_out); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
        @(posedge clk); #1;
        rst = 1'b0; fet_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", stall_fet_out); end
    endtask

    task automatic test_cold_miss();
        @(posedge clk); #1;
        fet_addr = 32'h0000_0010; fet_req_valid = 1'b1;
        serve_miss(line_a, 0, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 5) begin errors++; $display("FAIL cold_hit_cycle: got %0d want 5", hc); end
        checks++; if (sc !== 5) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 5", sc); end
        checks++; if (ins !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_inst: got %h want deadbeef", ins); end
        checks++; if (ra !== 32'h0000_0010) begin errors++; $display("FAIL cold_req_addr: got %h want 00000010", ra); end
        checks++; if (ac !== 1) begin errors++; $display("FAIL cold_accepts: got %0d want 1", ac); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL cold_hit_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_same_line();
        logic [127:0] line;
        logic [31:0]  exp;
        line = line_a;
        for (int i = 0; i < 4; i++) begin
            fet_addr = 32'h10 + 32'(4 * i); fet_req_valid = 1'b1;
            exp = line[32*i +: 32];
            @(negedge clk);
            checks++; if (fet_rdy !== 1'b1) begin errors++; $display("FAIL same_line_rdy[%0d]: got %b want 1", i, fet_rdy); end
            checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL same_line_stall[%0d]: got %b want 0", i, stall_fet_out); end
            checks++; if (fet_inst !== exp) begin errors++; $display("FAIL same_line_inst[%0d]: got %h want %h", i, fet_inst, exp); end
            @(posedge clk); #1;
        end
        fet_req_valid = 1'b0;
        checks++; if (hit_count !== 16'd5) begin errors++; $display("FAIL same_line_hit_count: got %0d want 5", hit_count); end
    endtask

    task automatic test_conflict();
        fet_addr = 32'h0000_0050; fet_req_valid = 1'b1;
        serve_miss(line_c, 0, 1, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (ra !== 32'h0000_0050) begin errors++; $display("FAIL conflict_req_addr: got %h want 00000050", ra); end
        checks++; if (hc !== 4) begin errors++; $display("FAIL conflict_hit_cycle: got %0d want 4", hc); end
        checks++; if (ins !== 32'h5555_0000) begin errors++; $display("FAIL conflict_inst: got %h want 55550000", ins); end
        @(posedge clk); #1;
        fet_addr = 32'h0000_0010;
        serve_miss(line_a, 0, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 5) begin errors++; $display("FAIL conflict_remiss_cycle: got %0d want 5", hc); end
        checks++; if (ra !== 32'h0000_0010) begin errors++; $display("FAIL conflict_remiss_addr: got %h want 00000010", ra); end
        checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        fet_addr = 32'h0000_0020; fet_req_valid = 1'b1;
        serve_miss(line_b, 5, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (rc !== 6) begin errors++; $display("FAIL bp_req_cycles: got %0d want 6", rc); end
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL bp_addr_stable: got %b want 0", mv); end
        checks++; if (ac !== 1) begin errors++; $display("FAIL bp_accepts: got %0d want 1", ac); end
        checks++; if (ra !== 32'h0000_0020) begin errors++; $display("FAIL bp_req_addr: got %h want 00000020", ra); end
        checks++; if (hc !== 10) begin errors++; $display("FAIL bp_hit_cycle: got %0d want 10", hc); end
        checks++; if (ins !== 32'hB0B0_0000) begin errors++; $display("FAIL bp_inst: got %h want b0b00000", ins); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    task automatic test_flush_idle();
        fet_addr = 32'h0000_0018; fet_req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++; if (fet_rdy !== 1'b1) begin errors++; $display("FAIL flush_same_cycle_rdy: got %b want 1", fet_rdy); end
        checks++; if (fet_inst !== 32'hCAFE_0002) begin errors++; $display("FAIL flush_same_cycle_inst: got %h want cafe0002", fet_inst); end
        @(posedge clk); #1;
        flush = 1'b0; fet_addr = 32'h0000_0020;
        serve_miss(line_b, 0, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 5) begin errors++; $display("FAIL flush_idle_remiss: got %0d want 5", hc); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    task automatic test_flush_mid_miss();
        m0 = 32'(miss_count);
        fet_addr = 32'h0000_0030; fet_req_valid = 1'b1;
        serve_miss(line_c, 0, 2, 2, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 10) begin errors++; $display("FAIL flush_mid_hit_cycle: got %0d want 10", hc); end
        checks++; if (ac !== 2) begin errors++; $display("FAIL flush_mid_accepts: got %0d want 2", ac); end
        checks++; if (32'(miss_count) - m0 !== 2) begin errors++; $display("FAIL flush_mid_miss_delta: got %0d want 2", 32'(miss_count) - m0); end
        checks++; if (ins !== 32'h5555_0000) begin errors++; $display("FAIL flush_mid_inst: got %h want 55550000", ins); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    task automatic test_stray_resp();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_b;
        @(negedge clk);
        checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL stray_stall: got %b want 0", stall_fet_out); end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        fet_addr = 32'h0000_0030; fet_req_valid = 1'b1;
        serve_miss(line_c, 0, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 5) begin errors++; $display("FAIL stray_no_fill: got %0d want 5", hc); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        fet_addr = 32'h0000_0070; fet_req_valid = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall_fet_out !== 1'b1) begin errors++; $display("FAIL rmm_miss_stall: got %b want 1", stall_fet_out); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_req_addr !== 32'h0000_0070) begin errors++; $display("FAIL rmm_req_addr: got %h want 00000070", mem_req_addr); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmm_during_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL rmm_during_stall: got %b want 0", stall_fet_out); end
        @(posedge clk); #1;
        rst = 1'b0; fet_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_b;
        @(negedge clk);
        checks++; if (stall_fet_out !== 1'b0) begin errors++; $display("FAIL rmm_after_stall: got %b want 0", stall_fet_out); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmm_after_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rmm_hit_count: got %0d want 0", hit_count); end
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL rmm_miss_count: got %0d want 0", miss_count); end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        fet_addr = 32'h0000_0070; fet_req_valid = 1'b1;
        serve_miss(line_c, 0, 2, -1, hc, sc, ac, rc, ra, mv, ins);
        checks++; if (hc !== 5) begin errors++; $display("FAIL rmm_line_invalid: got %0d want 5", hc); end
        @(posedge clk); #1;
        fet_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line();
        test_conflict();
        test_back_pressure();
        test_flush_idle();
        test_flush_mid_miss();
        test_stray_resp();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
